// File: rtl/seven_seg_capture.sv
// Samples a multiplexed 7-segment bus, debounces each {strobe,segment} sample
// with a run counter, and decodes stable patterns into one hex code per digit.
module seven_seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic [6:0]            I_SEG,
  input  logic [DIGITS-1:0]     I_DIG,
  output logic [4*DIGITS-1:0]   O_CODE,
  output logic [DIGITS-1:0]     O_VALID,
  output logic [DIGITS-1:0]     O_ERR,
  output logic [DIGITS-1:0]     O_UPD
);

  localparam int         SW  = DIGITS + 7;
  localparam logic [7:0] SC8 = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t                   r_state, w_state_nxt;
  logic [SW-1:0]            r_s;
  logic [7:0]               r_run, w_run_nxt;
  logic [DIGITS-1:0][3:0]   r_code;
  logic [DIGITS-1:0]        r_valid, r_err, r_upd;

  logic [SW-1:0]            w_sample;
  logic                     w_chg, w_in_onehot, w_commit;
  logic [4:0]               w_dec;
  logic                     w_hit, w_err;

  // {hit, code}; hit=0 for blank and for unrecognised patterns
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'h3F: return 5'h10;  7'h06: return 5'h11;
      7'h5B: return 5'h12;  7'h4F: return 5'h13;
      7'h66: return 5'h14;  7'h6D: return 5'h15;
      7'h7D: return 5'h16;  7'h07: return 5'h17;
      7'h7F: return 5'h18;  7'h6F: return 5'h19;
      7'h77: return 5'h1A;  7'h7C: return 5'h1B;
      7'h39: return 5'h1C;  7'h5E: return 5'h1D;
      7'h79: return 5'h1E;  7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign w_sample    = {I_DIG, I_SEG};
  assign w_chg       = (w_sample != r_s);
  assign w_in_onehot = $onehot(I_DIG);
  assign w_dec       = f_decode(r_s[6:0]);
  assign w_hit       = w_dec[4];
  assign w_err       = !w_hit && (r_s[6:0] != 7'h00);

  // Next state is judged on the sample being registered this edge, so RUN
  // and the state always describe the current contents of r_s.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_commit    = (r_state == TRACK) && (r_run == SC8);
    if (!w_in_onehot) begin
      w_state_nxt = IDLE;
      w_run_nxt   = 8'd0;
    end else if (w_chg || r_state == IDLE) begin
      w_state_nxt = TRACK;
      w_run_nxt   = 8'd1;
    end else begin
      if (r_run < SC8) w_run_nxt = r_run + 8'd1;
      if (w_commit)    w_state_nxt = HOLD;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_sample;
      r_run   <= w_run_nxt;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_code  <= '0;
      r_valid <= '0;
      r_err   <= '0;
      r_upd   <= '0;
    end else begin
      r_upd <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        if (w_commit && r_s[7+k]) begin
          if (w_hit) r_code[k] <= w_dec[3:0];
          r_valid[k] <= w_hit;
          r_err[k]   <= w_err;
          r_upd[k]   <= ({(w_hit ? w_dec[3:0] : r_code[k]), w_hit, w_err}
                         != {r_code[k], r_valid[k], r_err[k]});
        end
      end
    end
  end

  assign O_CODE  = r_code;
  assign O_VALID = r_valid;
  assign O_ERR   = r_err;
  assign O_UPD   = r_upd;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic [15:0] code;
  logic [3:0]  valid, err, upd;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt [4];

  seven_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .I_CLK  (clk),
    .I_RST  (rst),
    .I_SEG  (seg),
    .I_DIG  (dig),
    .O_CODE (code),
    .O_VALID(valid),
    .O_ERR  (err),
    .O_UPD  (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) upd_cnt[k] += int'(upd[k]);
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 4; k++) upd_cnt[k] = 0;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    dig = d;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    seg = 7'(($urandom));
    dig = 4'($urandom_range(0, 15));
    clr_cnt();

    // 1. reset with random bus activity
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_code", 32'(code), 32'h0);
      chk("rst_flags", 32'({valid, err, upd}), 32'h0);
      seg = 7'(($urandom));
      dig = 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
    tick();
    chk("rst_rel_code", 32'(code), 32'h0);
    chk("rst_rel_flags", 32'({valid, err, upd}), 32'h0);
    hold(7'h00, 4'b0000, 3);
    clr_cnt();

    // 2. latency: commit visible 5 edges after apply
    hold(7'h5B, 4'b0001, 4);
    chk("lat_early_valid", 32'(valid), 32'h0);
    hold(7'h5B, 4'b0001, 1);
    chk("lat_code", 32'(code[3:0]), 32'h2);
    chk("lat_valid", 32'(valid), 32'b0001);
    chk("lat_upd", 32'(upd), 32'b0001);
    hold(7'h5B, 4'b0001, 7);
    chk("lat_upd_once", 32'(upd_cnt[0]), 32'd1);
    clr_cnt();

    // 3. short 4F run must not commit
    hold(7'h4F, 4'b0001, 3);
    hold(7'h06, 4'b0001, 4);
    chk("glitch_hold", 32'(code[3:0]), 32'h2);
    hold(7'h06, 4'b0001, 4);
    chk("glitch_code", 32'(code[3:0]), 32'h1);
    chk("glitch_upd", 32'(upd_cnt[0]), 32'd1);
    clr_cnt();

    // 4. invalid then blank on digit 2
    hold(7'h7E, 4'b0100, 6);
    chk("inv_err", 32'(err), 32'b0100);
    chk("inv_valid", 32'(valid), 32'b0001);
    chk("inv_code", 32'(code[11:8]), 32'h0);
    hold(7'h00, 4'b0100, 6);
    chk("blank_err", 32'(err), 32'b0000);
    chk("blank_valid", 32'(valid), 32'b0001);
    chk("blank_upd", 32'(upd_cnt[2]), 32'd2);
    clr_cnt();

    // 5. two scan passes over all digits
    for (int p = 0; p < 2; p++) begin
      hold(7'h06, 4'b0001, 8);
      hold(7'h5B, 4'b0010, 8);
      hold(7'h4F, 4'b0100, 8);
      hold(7'h66, 4'b1000, 8);
      if (p == 0) begin
        chk("scan1_upd", 32'({upd_cnt[3][7:0], upd_cnt[2][7:0], upd_cnt[1][7:0], upd_cnt[0][7:0]}),
            32'h01010100);
        clr_cnt();
      end
    end
    chk("scan2_upd", 32'(upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]), 32'd0);
    chk("scan_code", 32'(code), 32'h4321);
    chk("scan_valid", 32'(valid), 32'b1111);
    chk("scan_err", 32'(err), 32'b0000);
    clr_cnt();

    // 6a. multi-hot strobes never commit
    hold(7'h06, 4'b0011, 20);
    chk("mh_code", 32'(code), 32'h4321);
    chk("mh_flags", 32'({valid, err}), 32'hF0);
    chk("mh_upd", 32'(upd_cnt[0] + upd_cnt[1]), 32'd0);

    // 6b. reset mid-run discards the run
    hold(7'h7F, 4'b0010, 1);
    rst = 1'b1;
    tick();
    chk("mr_rst_code", 32'(code), 32'h0);
    chk("mr_rst_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    hold(7'h7F, 4'b0010, 4);
    chk("mr_early_valid", 32'(valid), 32'h0);
    hold(7'h7F, 4'b0010, 1);
    chk("mr_code", 32'(code), 32'h0080);
    chk("mr_valid", 32'(valid), 32'b0010);
    chk("mr_upd", 32'(upd), 32'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
